// File: rtl/mem_to_st_pkg.sv
// Shared types and constants for the memory-to-stream reader.
package mem_to_st_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'b0001,
        READ_REQ  = 4'b0010,
        WAIT_DATA = 4'b0100,
        EMIT      = 4'b1000
    } state_e;

    localparam logic CSR_BASE   = 1'b0;
    localparam logic CSR_LENGTH = 1'b1;

endpackage

// File: rtl/mem_to_st.sv
// Reads whole memory words one at a time over Avalon-MM and replays them as a
// framed stream of OUT_WIDTH symbols, LSB slice first.
module mem_to_st
    import mem_to_st_pkg::*;
#(
    parameter int OUT_WIDTH     = 32,
    parameter int READ_WIDTH    = 256,
    parameter int ADDRESS_WIDTH = 32,
    parameter int LENGTH_WIDTH  = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     csr_write,
    input  logic                     csr_address,
    input  logic [ADDRESS_WIDTH-1:0] csr_writedata,
    output logic                     busy,
    output logic                     mem_read,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    input  logic                     mem_waitrequest,
    input  logic [READ_WIDTH-1:0]    mem_readdata,
    input  logic                     mem_readdatavalid,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_WIDTH-1:0]     out_data,
    output logic                     out_sop,
    output logic                     out_eop
);

    localparam int SYMBOLS_PER_READ = READ_WIDTH / OUT_WIDTH;
    localparam int IDX_WIDTH = (SYMBOLS_PER_READ > 1) ? $clog2(SYMBOLS_PER_READ) : 1;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(SYMBOLS_PER_READ - 1);
    localparam logic [ADDRESS_WIDTH-1:0] WORD_BYTES = ADDRESS_WIDTH'(READ_WIDTH / 8);

    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] base_q, base_d;
    logic [ADDRESS_WIDTH-1:0] offset_q, offset_d;
    logic [LENGTH_WIDTH-1:0]  remaining_q, remaining_d;
    logic [IDX_WIDTH-1:0]     idx_q, idx_d;
    logic [READ_WIDTH-1:0]    buffer_q, buffer_d;
    logic                     first_q, first_d;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        offset_d    = offset_q;
        remaining_d = remaining_q;
        idx_d       = idx_q;
        buffer_d    = buffer_q;
        first_d     = first_q;

        unique case (state_q)
            IDLE: begin
                if (csr_write) begin
                    if (csr_address == CSR_BASE) begin
                        base_d = csr_writedata;
                    end else if (csr_writedata[LENGTH_WIDTH-1:0] != '0) begin
                        remaining_d = csr_writedata[LENGTH_WIDTH-1:0];
                        offset_d    = '0;
                        idx_d       = '0;
                        first_d     = 1'b1;
                        state_d     = READ_REQ;
                    end
                end
            end
            READ_REQ: begin
                if (!mem_waitrequest) begin
                    state_d = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (mem_readdatavalid) begin
                    buffer_d = mem_readdata;
                    idx_d    = '0;
                    state_d  = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    remaining_d = remaining_q - 1'b1;
                    idx_d       = idx_q + 1'b1;
                    first_d     = 1'b0;
                    // Last symbol wins over word exhaustion so leftover slices are dropped.
                    if (remaining_q == LENGTH_WIDTH'(1)) begin
                        state_d = IDLE;
                    end else if (idx_q == LAST_IDX) begin
                        offset_d = offset_q + WORD_BYTES;
                        state_d  = READ_REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            base_q      <= '0;
            offset_q    <= '0;
            remaining_q <= '0;
            idx_q       <= '0;
            buffer_q    <= '0;
            first_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            offset_q    <= offset_d;
            remaining_q <= remaining_d;
            idx_q       <= idx_d;
            buffer_q    <= buffer_d;
            first_q     <= first_d;
        end
    end

    // Outputs decode registered state only, so they stay put while stalled.
    assign busy        = (state_q != IDLE);
    assign mem_read    = (state_q == READ_REQ);
    assign mem_address = mem_read ? (base_q + offset_q) : '0;
    assign out_valid   = (state_q == EMIT);
    assign out_data    = out_valid ? buffer_q[idx_q*OUT_WIDTH +: OUT_WIDTH] : '0;
    assign out_sop     = out_valid && first_q;
    assign out_eop     = out_valid && (remaining_q == LENGTH_WIDTH'(1));

endmodule

// File: doc/mem_to_st.md
MEM_TO_ST -- requirements
Module: mem_to_st

Interface
REQ-001 SHALL have parameter OUT_WIDTH, default 32, stream symbol width in bits.
REQ-002 SHALL have parameter READ_WIDTH, default 256, memory read word width in bits, an integer multiple of OUT_WIDTH; SYMBOLS_PER_READ = READ_WIDTH/OUT_WIDTH.
REQ-003 SHALL have parameter ADDRESS_WIDTH, default 32, memory byte-address width.
REQ-004 SHALL have parameter LENGTH_WIDTH, default 16, transfer-length width in symbols.
REQ-005 SHALL have port clock, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port csr_write, input, 1, CSR write strobe.
REQ-008 SHALL have port csr_address, input, 1: 0 selects the base-address register, 1 selects length/start.
REQ-009 SHALL have port csr_writedata, input, ADDRESS_WIDTH, CSR write data.
REQ-010 SHALL have port busy, output, 1, high while a transfer is in progress.
REQ-011 SHALL have port mem_read, output, 1, Avalon-MM read request.
REQ-012 SHALL have port mem_address, output, ADDRESS_WIDTH, read byte address.
REQ-013 SHALL have port mem_waitrequest, input, 1, slave stall.
REQ-014 SHALL have port mem_readdata, input, READ_WIDTH, read data.
REQ-015 SHALL have port mem_readdatavalid, input, 1, read data qualifier.
REQ-016 SHALL have port out_valid, output, 1, stream symbol valid.
REQ-017 SHALL have port out_ready, input, 1, sink accepts the symbol.
REQ-018 SHALL have port out_data, output, OUT_WIDTH, stream symbol.
REQ-019 SHALL have port out_sop, output, 1, first symbol of the transfer.
REQ-020 SHALL have port out_eop, output, 1, last symbol of the transfer.

Function
REQ-021 SHALL use one-hot states IDLE, READ_REQ, WAIT_DATA, EMIT; busy = (state != IDLE).
REQ-022 SHALL load base from csr_writedata on a csr_write to address 0 in IDLE only; writes while busy are ignored.
REQ-023 SHALL, on a csr_write to address 1 in IDLE with csr_writedata[LENGTH_WIDTH-1:0] != 0, load remaining with that value, clear offset and symbol index, and go to READ_REQ next cycle; a zero length or a write while busy is a no-op.
REQ-024 SHALL, in READ_REQ, drive mem_read=1 and mem_address=base+offset (modulo 2^ADDRESS_WIDTH), hold both stable while mem_waitrequest=1, and go to WAIT_DATA on the cycle mem_waitrequest=0.
REQ-025 SHALL issue at most one outstanding read; in WAIT_DATA, mem_readdatavalid=1 captures mem_readdata into the word buffer, clears the symbol index, and goes to EMIT; mem_readdatavalid outside WAIT_DATA is ignored.
REQ-026 SHALL, in EMIT, drive out_valid=1 and out_data = buffer[idx*OUT_WIDTH +: OUT_WIDTH]; symbol 0 is the least-significant slice.
REQ-027 SHALL assert out_sop on the first symbol of a transfer only, and out_eop when remaining==1; a length-1 transfer asserts both together.
REQ-028 SHALL hold out_data, out_sop, and out_eop stable while out_valid=1 and out_ready=0.
REQ-029 SHALL, on an accepted symbol (out_valid and out_ready), decrement remaining and increment idx; if the symbol was the last, go to IDLE; else if idx==SYMBOLS_PER_READ-1, add READ_WIDTH/8 to offset and go to READ_REQ; else stay in EMIT.
REQ-030 SHALL discard unused trailing symbols of the final word when length is not a multiple of SYMBOLS_PER_READ.
REQ-031 SHALL drive mem_address=0 when mem_read=0, and out_data=0 when out_valid=0.

Reset
REQ-032 SHALL, on reset (also mid-transfer), abort any transfer and enter IDLE; base, offset, remaining, and idx become 0; busy, mem_read, out_valid, out_sop, and out_eop become 0.
REQ-033 SHALL ignore any read response arriving after a reset-abort.

Structure
REQ-034 SHALL place the state enum and CSR address constants (CSR_BASE=0, CSR_LENGTH=1) in package mem_to_st_pkg.
REQ-035 SHALL be a single module with no sub-modules.

Verification
REQ-036 SHALL test base=0x1000, length=8, no stalls: one read at 0x1000, then symbols 0..7 with sop on symbol 0, eop on symbol 7, then busy=0.
REQ-037 SHALL test base=0x2000, length=10: reads at 0x2000 and 0x2020, 10 symbols emitted, and upper 6 symbols of the second word discarded.
REQ-038 SHALL test mem_waitrequest held for 3 cycles: mem_read and mem_address stay stable all 3 cycles, and exactly one request completes.
REQ-039 SHALL test out_ready toggled 1,0,0,1 pseudo-randomly: no symbol is lost or duplicated, and data stays stable while stalled.
REQ-040 SHALL test length=1: a single symbol with out_sop=out_eop=1; a length=0 write leaves busy=0.
REQ-041 SHALL test reset asserted during EMIT of a length-16 transfer: outputs go to 0 next cycle, a late mem_readdatavalid is ignored, and a new transfer starts cleanly.
